// File: rtl/fp_pkg.sv
// Shared constants and types for the float add/sub issue/collect sequencer.
package fp_pkg;

  localparam logic [1:0] ENABLE_OFF = 2'b00;
  localparam logic [1:0] ENABLE_ADD = 2'b01;
  localparam logic [1:0] ENABLE_SUB = 2'b10;

  localparam logic [1:0] OVF_OK   = 2'b00;
  localparam logic [1:0] OVF_UP   = 2'b01;
  localparam logic [1:0] OVF_DOWN = 2'b10;
  localparam logic [1:0] OVF_BAD  = 2'b11;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_MIN_WAIT   = 60;
  localparam int DEF_STABLE_CNT = 3;
  localparam int DEF_MAX_WAIT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SETTLE,
    ST_CAPTURE
  } seq_state_e;

  typedef struct packed {
    logic        sub;
    logic [31:0] x;
    logic [31:0] y;
  } op_pair_t;

  // Counters hold at their maximum instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of {sub,x,y}, extra pointer bit separates full from empty.
module fp_op_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  op_pair_t push_data,
  input  logic     pop,
  output op_pair_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  op_pair_t       mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Issues buffered operand pairs to the multi-cycle float add/sub unit and collects results
// using a minimum wait plus a stability window, since the unit has no done flag.
module fp_addsub_sequencer
  import fp_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int MIN_WAIT   = DEF_MIN_WAIT,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic        in_sub,
  output logic [1:0]  fpu_enable,
  output logic [31:0] fpu_x,
  output logic [31:0] fpu_y,
  input  logic [31:0] fpu_z,
  input  logic [1:0]  fpu_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [1:0]  out_ovf,
  output logic        timeout
);

  localparam logic [7:0] MIN_LAST  = 8'(MIN_WAIT - 1);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CNT - 1);
  localparam logic [7:0] MAX_LAST  = 8'(MAX_WAIT - 1);

  seq_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  stab_q, stab_d;
  logic [33:0] prev_q, prev_d;
  logic [31:0] fpu_x_q, fpu_x_d;
  logic [31:0] fpu_y_q, fpu_y_d;
  logic [1:0]  fpu_en_q, fpu_en_d;
  logic [31:0] out_z_q, out_z_d;
  logic [1:0]  out_ovf_q, out_ovf_d;
  logic        out_valid_q, out_valid_d;
  logic        timeout_q, timeout_d;

  op_pair_t    push_data, head;
  logic        fifo_full, fifo_empty, pop;
  logic [33:0] sample;
  logic        stable_done;

  assign push_data = '{sub: in_sub, x: in_x, y: in_y};
  assign in_ready  = !fifo_full;
  assign sample    = {fpu_z, fpu_ovf};

  fp_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    prev_d      = prev_q;
    fpu_x_d     = fpu_x_q;
    fpu_y_d     = fpu_y_q;
    fpu_en_d    = fpu_en_q;
    out_z_d     = out_z_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    timeout_d   = timeout_q;
    pop         = 1'b0;
    stable_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fpu_en_d = ENABLE_OFF;
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        pop      = 1'b1;
        fpu_x_d  = head.x;
        fpu_y_d  = head.y;
        fpu_en_d = head.sub ? ENABLE_SUB : ENABLE_ADD;
        cnt_d    = '0;
        stab_d   = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d  = sat_inc(cnt_q);
        prev_d = sample;
        if (cnt_q == MIN_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d  = sat_inc(cnt_q);
        prev_d = sample;
        if (sample == prev_q) begin
          stab_d      = sat_inc(stab_q);
          stable_done = (stab_q == STAB_LAST);
        end else begin
          stab_d = '0;
        end
        // A settled result wins over the timeout when both land on the same cycle.
        if (stable_done) begin
          state_d = ST_CAPTURE;
        end else if (cnt_q == MAX_LAST) begin
          state_d   = ST_CAPTURE;
          timeout_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!out_valid_q || out_ready) begin
          out_z_d     = fpu_z;
          out_ovf_d   = fpu_ovf;
          out_valid_d = 1'b1;
          if (fifo_empty) begin
            state_d  = ST_IDLE;
            fpu_en_d = ENABLE_OFF;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stab_q      <= '0;
      prev_q      <= '0;
      fpu_x_q     <= '0;
      fpu_y_q     <= '0;
      fpu_en_q    <= ENABLE_OFF;
      out_z_q     <= '0;
      out_ovf_q   <= OVF_OK;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      prev_q      <= prev_d;
      fpu_x_q     <= fpu_x_d;
      fpu_y_q     <= fpu_y_d;
      fpu_en_q    <= fpu_en_d;
      out_z_q     <= out_z_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign fpu_enable = fpu_en_q;
  assign fpu_x      = fpu_x_q;
  assign fpu_y      = fpu_y_q;
  assign out_z      = out_z_q;
  assign out_ovf    = out_ovf_q;
  assign out_valid  = out_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Self-checking bench for fp_addsub_sequencer with a behavioural stand-in for the float add/sub unit.
module tb_fp_addsub_sequencer;
  import fp_pkg::*;

  localparam int DEPTH      = 4;
  localparam int MIN_WAIT   = 60;
  localparam int STABLE_CNT = 3;
  localparam int MAX_WAIT   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic        in_sub = 1'b0;
  logic [1:0]  fpu_enable;
  logic [31:0] fpu_x, fpu_y;
  logic [31:0] u_z;
  logic [1:0]  u_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_z;
  logic [1:0]  out_ovf;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  int delivered = 0;
  bit chaos = 1'b0;
  bit rand_ready = 1'b0;

  logic [31:0] pair_x [16];
  logic [31:0] pair_y [16];
  logic        pair_s [16];

  always #5 clk = ~clk;

  fp_addsub_sequencer #(
    .DEPTH(DEPTH), .MIN_WAIT(MIN_WAIT), .STABLE_CNT(STABLE_CNT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_sub     (in_sub),
    .fpu_enable (fpu_enable),
    .fpu_x      (fpu_x),
    .fpu_y      (fpu_y),
    .fpu_z      (u_z),
    .fpu_ovf    (u_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_ovf    (out_ovf),
    .timeout    (timeout)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // What the unit eventually settles to: known vectors exactly, a bad-input code for
  // all-ones exponents, and otherwise an arbitrary but deterministic pattern.
  function automatic logic [33:0] unit_model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    if (x == 32'h3F800000 && y == 32'h40000000 && !sub) return {32'h40400000, OVF_OK};
    if (x == 32'h40400000 && y == 32'h3F800000 && sub)  return {32'h40000000, OVF_OK};
    if (x == 32'h00000000 && y == 32'h40A00000 && !sub) return {32'h40A00000, OVF_OK};
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)         return {32'h00000001, OVF_BAD};
    return {sub ? x - y : x + y, 1'b0, x[0] ^ y[0]};
  endfunction

  // Stand-in unit: restarts on any operand/enable change, shows junk for a random latency
  // well under MIN_WAIT, then holds the result; freezes when enable is 0. In chaos mode z never settles.
  logic [31:0] u_lx, u_ly;
  logic [1:0]  u_len;
  int          u_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_z <= '0; u_ovf <= '0; u_lx <= '0; u_ly <= '0; u_len <= '0; u_busy <= 0;
    end else if (fpu_enable != ENABLE_OFF) begin
      if (fpu_enable != u_len || fpu_x != u_lx || fpu_y != u_ly) begin
        u_len <= fpu_enable; u_lx <= fpu_x; u_ly <= fpu_y;
        u_busy <= int'($urandom_range(40, 3));
        u_z <= $urandom; u_ovf <= 2'($urandom);
      end else if (chaos) begin
        u_z <= u_z + 32'd1;
      end else if (u_busy > 1) begin
        u_busy <= u_busy - 1;
        u_z <= $urandom; u_ovf <= 2'($urandom);
      end else if (u_busy == 1) begin
        u_busy <= 0;
        {u_z, u_ovf} <= unit_model(u_lx, u_ly, u_len == ENABLE_SUB);
      end
    end
  end

  // In-order scoreboard; sampled at the falling edge, i.e. the values the next rising edge acts on.
  typedef struct { logic [33:0] res; bit dont_care; } exp_t;
  exp_t        exp_q [$];
  logic [33:0] last_out;
  bit          hold_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (in_valid && in_ready) begin
        e.res = unit_model(in_x, in_y, in_sub);
        e.dont_care = chaos;
        exp_q.push_back(e);
        accepted++;
      end
      if (hold_prev) checkOutput("out_hold", {30'd0, out_z, out_ovf}, {30'd0, last_out});
      hold_prev = out_valid && !out_ready;
      last_out  = {out_z, out_ovf};
      if (out_valid && out_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL out_extra: got result %0h, expected no result", {out_z, out_ovf});
        end else begin
          e = exp_q.pop_front();
          if (!e.dont_care) checkOutput("out_result", {30'd0, out_z, out_ovf}, {30'd0, e.res});
        end
      end
    end else begin
      exp_q.delete();
      hold_prev = 1'b0;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom);
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic sub);
    in_valid = 1'b1; in_x = x; in_y = y; in_sub = sub;
    for (int c = 0; c < 400; c++) begin
      if (in_ready) begin
        stepCycle();
        in_valid = 1'b0;
        return;
      end
      stepCycle();
    end
    in_valid = 1'b0;
    checks++; failures++;
    $display("[TB] FAIL push_accept: got in_ready=0 for 400 cycles, expected acceptance");
  endtask

  task automatic offerPairs(input int first, input int n, input int cycles, input bit gaps);
    int base = accepted;
    int k;
    for (int c = 0; c < cycles; c++) begin
      k = accepted - base;
      if (k >= n) break;
      in_valid = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
      in_x = pair_x[first + k]; in_y = pair_y[first + k]; in_sub = pair_s[first + k];
      stepCycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int bound, output int lat);
    lat = -1;
    for (int c = 1; c <= bound; c++) begin
      stepCycle();
      if (out_valid) begin
        lat = c;
        return;
      end
    end
    checks++; failures++;
    $display("[TB] FAIL out_valid_wait: got no out_valid in %0d cycles, expected a result", bound);
  endtask

  task automatic waitEnable(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (fpu_enable != ENABLE_OFF) return;
      stepCycle();
    end
    checks++; failures++;
    $display("[TB] FAIL enable_wait: got fpu_enable=0 for %0d cycles, expected issue", bound);
  endtask

  task automatic drainAll(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (exp_q.size() == 0 && !out_valid && !in_valid) return;
      stepCycle();
    end
    checks++; failures++;
    $display("[TB] FAIL drain: got %0d results outstanding after %0d cycles, expected 0", exp_q.size(), bound);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},   64'(in_ready),   64'd1);
    checkOutput({tag, "_fpu_enable"}, 64'(fpu_enable), 64'd0);
    checkOutput({tag, "_fpu_x"},      64'(fpu_x),      64'd0);
    checkOutput({tag, "_fpu_y"},      64'(fpu_y),      64'd0);
    checkOutput({tag, "_out_valid"},  64'(out_valid),  64'd0);
    checkOutput({tag, "_out_z"},      64'(out_z),      64'd0);
    checkOutput({tag, "_out_ovf"},    64'(out_ovf),    64'd0);
    checkOutput({tag, "_timeout"},    64'(timeout),    64'd0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic [31:0] z;
    logic [1:0]  ovf;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   lat;
    int   base;
    int   got;

    vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00};
    vecs[1] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 2'b00};
    vecs[2] = '{32'h00000000, 32'h40A00000, 1'b0, 32'h40A00000, 2'b00};
    vecs[3] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h00000001, 2'b11};

    #3;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    // Directed vectors, one at a time with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].sub);
      waitEnable(6);
      checkOutput("vec_enable", 64'(fpu_enable), vecs[i].sub ? 64'd2 : 64'd1);
      checkOutput("vec_fpu_x", 64'(fpu_x), 64'(vecs[i].x));
      checkOutput("vec_fpu_y", 64'(fpu_y), 64'(vecs[i].y));
      waitOutValid(200, lat);
      lat = lat + 2;
      checkOutput("vec_out_z", 64'(out_z), 64'(vecs[i].z));
      checkOutput("vec_out_ovf", 64'(out_ovf), 64'(vecs[i].ovf));
      checkOutput("vec_min_wait_respected", 64'(lat >= MIN_WAIT + STABLE_CNT), 64'd1);
      checkOutput("vec_no_timeout", 64'(timeout), 64'd0);
      stepCycle();
      checkOutput("vec_single_pulse", 64'(out_valid), 64'd0);
      checkOutput("vec_idle_enable", 64'(fpu_enable), 64'd0);
    end

    // Same pair twice back to back: both captured normally, no timeout.
    base = delivered;
    pair_x[0] = 32'h3F800000; pair_y[0] = 32'h40000000; pair_s[0] = 1'b0;
    pair_x[1] = 32'h3F800000; pair_y[1] = 32'h40000000; pair_s[1] = 1'b0;
    offerPairs(0, 2, 20, 1'b0);
    drainAll(400);
    checkOutput("b2b_count", 64'(delivered - base), 64'd2);
    checkOutput("b2b_no_timeout", 64'(timeout), 64'd0);

    // Back-pressure: one result held in the output register, one pair held in capture, DEPTH queued.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pair_x[i] = $urandom; pair_y[i] = $urandom; pair_s[i] = 1'($urandom);
    end
    base = accepted;
    offerPairs(0, 8, 300, 1'b0);
    got = accepted - base;
    checkOutput("bp_accepted", 64'(got), 64'(DEPTH + 2));
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    offerPairs(got, 8 - got, 1500, 1'b0);
    checkOutput("bp_total_accepted", 64'(accepted - base), 64'd8);
    drainAll(1500);

    // Randomised traffic with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pair_x[i] = ($urandom_range(7, 0) == 0) ? 32'h7F800000 : $urandom;
      pair_y[i] = $urandom; pair_s[i] = 1'($urandom);
    end
    base = accepted;
    offerPairs(0, 12, 3000, 1'b1);
    checkOutput("rand_accepted", 64'(accepted - base), 64'd12);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drainAll(1500);
    checkOutput("rand_no_timeout", 64'(timeout), 64'd0);

    // Result that never settles: forced capture at MAX_WAIT, sticky timeout flag.
    chaos = 1'b1;
    applyStimulus(32'h12345678, 32'h0BADF00D, 1'b0);
    waitOutValid(400, lat);
    lat = lat + 1;
    checkOutput("timeout_flag", 64'(timeout), 64'd1);
    checkOutput("timeout_latency_ge_max", 64'(lat >= MAX_WAIT), 64'd1);
    checkOutput("timeout_latency_bounded", 64'(lat <= MAX_WAIT + 8), 64'd1);
    stepCycle();
    chaos = 1'b0;
    applyStimulus(vecs[0].x, vecs[0].y, vecs[0].sub);
    drainAll(300);
    checkOutput("timeout_sticky", 64'(timeout), 64'd1);

    // Reset while the unit is being waited on: immediate return to reset values, nothing stale after.
    applyStimulus(vecs[1].x, vecs[1].y, vecs[1].sub);
    for (int c = 0; c < 20; c++) stepCycle();
    checkOutput("pre_reset_busy", 64'(fpu_enable), 64'd2);
    #1 rst = 1'b0;
    #1;
    checkResetState("midreset");
    @(negedge clk);
    #2 rst = 1'b1;
    base = delivered;
    for (int c = 0; c < 150; c++) stepCycle();
    checkOutput("no_stale_result", 64'(delivered - base), 64'd0);
    checkOutput("no_stale_valid", 64'(out_valid), 64'd0);
    checkOutput("no_stale_enable", 64'(fpu_enable), 64'd0);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion by time %0t, expected earlier finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
